// File: rtl/rf_writeback_ctrl_if.sv
// rf_writeback_ctrl_if
//   Bundles every signal between the register-file write-back controller and
//   its neighbours. The three producer streams, the decode query port and the
//   register-file write port are grouped here.
//   Handshake semantics for all streams:
//     a stream : a_valid alone qualifies a_index/a_data. It is always taken,
//                and there is no ready signal.
//     issue    : the op is recorded only in a cycle where issue_valid and
//                issue_ready are both high. issue_ready depends on the current
//                issue_index.
//     b stream : the result is transferred in a cycle where b_valid and
//                b_ready are both high. b_ready does not depend on b_valid.
//   Modports:
//     master : producers, decode and the register file (drive requests, see responses)
//     slave  : the controller itself
interface rf_writeback_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int IDX_W = $clog2(NREGS);

  logic             a_valid;
  logic [IDX_W-1:0] a_index;
  logic [XLEN-1:0]  a_data;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_index;
  logic             issue_ready;
  logic             b_valid;
  logic [IDX_W-1:0] b_index;
  logic [XLEN-1:0]  b_data;
  logic             b_ready;
  logic [IDX_W-1:0] query_index1;
  logic [IDX_W-1:0] query_index2;
  logic             busy1;
  logic             busy2;
  logic             write_enable;
  logic [IDX_W-1:0] write_index;
  logic [XLEN-1:0]  write_data;
  logic             proto_error;

  modport master (
    output a_valid, a_index, a_data,
    output issue_valid, issue_index,
    output b_valid, b_index, b_data,
    output query_index1, query_index2,
    input  issue_ready, b_ready, busy1, busy2,
    input  write_enable, write_index, write_data, proto_error
  );

  modport slave (
    input  a_valid, a_index, a_data,
    input  issue_valid, issue_index,
    input  b_valid, b_index, b_data,
    input  query_index1, query_index2,
    output issue_ready, b_ready, busy1, busy2,
    output write_enable, write_index, write_data, proto_error
  );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
//   Write-side controller for the register file. It merges the single-cycle
//   result stream (a) and the long-latency result stream (b) onto the one
//   register-file write port. Stream a always has priority. Stream b results
//   wait in a small FIFO. A pending-register scoreboard marks destinations of
//   long-latency ops that are still in flight, so decode can stall on hazards.
// Ports
//   clk    : clock, all state changes on posedge
//   reset  : asynchronous, active-high
//   bus    : rf_writeback_ctrl_if.slave. It carries the a/issue/b streams,
//            the decode queries (busy1/2), the registered write port and the
//            sticky proto_error flag.
module rf_writeback_ctrl #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  rf_writeback_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(NREGS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(NREGS + 1);

  // FIFO storage has no reset. Only the pointers and the count define
  // which entries are valid.
  logic [IDX_W-1:0] fifo_idx  [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, push, pop;
  logic [IDX_W-1:0] head_idx;
  logic [XLEN-1:0]  head_data;

  logic [NREGS-1:0] pending, pending_next;
  logic [OUT_W-1:0] outstanding;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_index;
  logic [XLEN-1:0]  sel_data;
  logic             proto_hit;

  logic             we_q;
  logic [IDX_W-1:0] wi_q;
  logic [XLEN-1:0]  wd_q;
  logic             proto_q;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign head_idx  = fifo_idx[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // b_ready comes only from the count as it stood at the start of the cycle.
  // A pop in the same cycle therefore frees space no earlier than the next cycle.
  assign bus.b_ready = !reset && !full;
  assign push        = bus.b_valid && bus.b_ready;
  // The head drains only in cycles where the pipeline stream is idle.
  assign pop         = !bus.a_valid && !empty;

  // Arbitration: stream a first, then the FIFO head.
  always_comb begin
    sel_valid = 1'b0;
    sel_index = '0;
    sel_data  = '0;
    if (bus.a_valid) begin
      sel_valid = 1'b1;
      sel_index = bus.a_index;
      sel_data  = bus.a_data;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_index = head_idx;
      sel_data  = head_data;
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NREGS; i++) begin
      outstanding = outstanding + OUT_W'(pending[i]);
    end
  end

  // Both terms use pending as it stands before this cycle's update. A register
  // cleared by a pop this cycle becomes issuable only in the next cycle.
  assign bus.issue_ready = !pending[bus.issue_index] &&
                           (outstanding < OUT_W'(FIFO_DEPTH));
  assign bus.busy1 = pending[bus.query_index1];
  assign bus.busy2 = pending[bus.query_index2];

  // The pop clear is applied before the issue set. The scoreboard never
  // tracks register 0.
  always_comb begin
    pending_next = pending;
    if (pop) begin
      pending_next[head_idx] = 1'b0;
    end
    if (bus.issue_valid && bus.issue_ready && (bus.issue_index != '0)) begin
      pending_next[bus.issue_index] = 1'b1;
    end
  end

  assign proto_hit = (push && !pending[bus.b_index]) ||
                     (bus.a_valid && (bus.a_index != '0) && pending[bus.a_index]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr]  <= bus.b_index;
      fifo_data[wr_ptr] <= bus.b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      proto_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      pending <= pending_next;
      if (proto_hit) proto_q <= 1'b1;
    end
  end

  // When nothing is committed, write_index and write_data keep the last
  // committed value. A selected write to x0 is dropped, and its FIFO entry
  // is still consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q <= 1'b0;
      wi_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= sel_valid && (sel_index != '0);
      if (sel_valid && (sel_index != '0)) begin
        wi_q <= sel_index;
        wd_q <= sel_data;
      end
    end
  end

  assign bus.write_enable = we_q;
  assign bus.write_index  = wi_q;
  assign bus.write_data   = wd_q;
  assign bus.proto_error  = proto_q;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb_rf_writeback_ctrl
//   Directed and random stimulus for rf_writeback_ctrl. A transaction-level
//   reference model tracks the buffered results as a queue and the in-flight
//   registers as a bit set. Each cycle the bench checks every output against
//   that model.
module tb_rf_writeback_ctrl;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  rf_writeback_ctrl_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  rf_writeback_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [36:0] exp_q[$];       // {index, data} of buffered long-latency results
  logic [31:0] m_pend;         // registers with an outstanding long-latency write
  logic        m_we;
  logic [4:0]  m_wi;
  logic [31:0] m_wd;
  logic        m_proto;
  logic        s_issue_ready;  // last sampled combinational outputs
  logic        s_b_ready;
  logic        s_busy1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pend  = '0;
    m_we    = 1'b0;
    m_wi    = '0;
    m_wd    = '0;
    m_proto = 1'b0;
  endtask

  // Runs one clock cycle. Inputs are applied at the negedge, and the
  // combinational outputs are checked 1 ns later. The registered outputs are
  // checked 1 ns after the posedge.
  task automatic cycle(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ii,
                       input logic bv, input logic [4:0] bi, input logic [31:0] bd);
    logic        e_ir, e_br, push, fire;
    logic [36:0] head;
    logic [31:0] pend_pre;
    @(negedge clk);
    bus.a_valid = av; bus.a_index = ai; bus.a_data = ad;
    bus.issue_valid = iv; bus.issue_index = ii;
    bus.b_valid = bv; bus.b_index = bi; bus.b_data = bd;
    #1;
    e_ir = !m_pend[ii] && ($countones(m_pend) < DEPTH);
    e_br = (exp_q.size() < DEPTH);
    s_issue_ready = bus.issue_ready;
    s_b_ready     = bus.b_ready;
    s_busy1       = bus.busy1;
    check("issue_ready", {31'd0, bus.issue_ready}, {31'd0, e_ir});
    check("b_ready", {31'd0, bus.b_ready}, {31'd0, e_br});
    check("busy1", {31'd0, bus.busy1}, {31'd0, m_pend[bus.query_index1]});
    check("busy2", {31'd0, bus.busy2}, {31'd0, m_pend[bus.query_index2]});
    pend_pre = m_pend;
    push = bv && e_br;
    fire = iv && e_ir;
    if (av) begin
      m_we = (ai != 0);
      if (ai != 0) begin m_wi = ai; m_wd = ad; end
    end else if (exp_q.size() != 0) begin
      head = exp_q.pop_front();
      m_we = (head[36:32] != 0);
      if (head[36:32] != 0) begin m_wi = head[36:32]; m_wd = head[31:0]; end
      m_pend[head[36:32]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (fire && ii != 0) m_pend[ii] = 1'b1;
    if (push) exp_q.push_back({bi, bd});
    if ((push && !pend_pre[bi]) || (av && ai != 0 && pend_pre[ai])) m_proto = 1'b1;
    @(posedge clk);
    #1;
    check("write_enable", {31'd0, bus.write_enable}, {31'd0, m_we});
    check("write_index", {27'd0, bus.write_index}, {27'd0, m_wi});
    check("write_data", bus.write_data, m_wd);
    check("proto_error", {31'd0, bus.proto_error}, {31'd0, m_proto});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.a_valid = 1'b0; bus.issue_valid = 1'b0; bus.b_valid = 1'b0;
    #1;
    check("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
    @(posedge clk); #1;
    check("rst_write_enable", {31'd0, bus.write_enable}, 32'd0);
    check("rst_write_index", {27'd0, bus.write_index}, 32'd0);
    check("rst_write_data", bus.write_data, 32'd0);
    check("rst_proto_error", {31'd0, bus.proto_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    compared = 0; mismatched = 0;
    reset = 1'b1;
    bus.a_valid = 0; bus.a_index = 0; bus.a_data = 0;
    bus.issue_valid = 0; bus.issue_index = 0;
    bus.b_valid = 0; bus.b_index = 0; bus.b_data = 0;
    bus.query_index1 = 0; bus.query_index2 = 0;
    model_clear();
    do_reset();

    // 1: single pipeline write, one-cycle latency
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    check("t1_we", {31'd0, bus.write_enable}, 32'd1);
    check("t1_index", {27'd0, bus.write_index}, 32'd5);
    check("t1_data", bus.write_data, 32'hDEADBEEF);
    idle();

    // 2: a wins over FIFO head, busy holds until after the pop
    bus.query_index1 = 5'd7; bus.query_index2 = 5'd3;
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12);
    check("t2_first_index", {27'd0, bus.write_index}, 32'd3);
    check("t2_busy7_before", {31'd0, s_busy1}, 32'd1);
    idle();
    check("t2_second_index", {27'd0, bus.write_index}, 32'd7);
    check("t2_second_data", bus.write_data, 32'h12);
    check("t2_busy7_popcycle", {31'd0, s_busy1}, 32'd1);
    idle();
    check("t2_busy7_after", {31'd0, s_busy1}, 32'd0);

    // 3: fill the FIFO behind a held a stream, then drain in order
    for (int r = 10; r < 14; r++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 5'd20, 32'(k), 1'b0, 5'd0, (k < 5), 5'(10 + k), 32'hB0 + 32'(k));
    check("t3_full_b_ready", {31'd0, s_b_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check("t3_drain_index", {27'd0, bus.write_index}, 32'(10 + k));
    end
    idle();

    // 4: index 0 writes and issues are invisible
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
    check("t4_we_x0", {31'd0, bus.write_enable}, 32'd0);
    bus.query_index1 = 5'd0;
    idle();
    check("t4_busy_x0", {31'd0, s_busy1}, 32'd0);

    // 5: double issue blocked, then an unissued b result flags an error
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    check("t5_reissue_ready", {31'd0, s_issue_ready}, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44);
    check("t5_proto", {31'd0, bus.proto_error}, 32'd1);
    idle(); idle();

    // 6: reset with three buffered results
    do_reset();
    for (int r = 1; r < 4; r++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0, 5'd0, 32'd0);
    for (int r = 1; r < 4; r++) cycle(1'b1, 5'd25, 32'd0, 1'b0, 5'd0, 1'b1, 5'(r), 32'(r));
    do_reset();
    bus.query_index1 = 5'd2;
    idle();
    check("t6_busy_after_reset", {31'd0, s_busy1}, 32'd0);
    check("t6_we_after_reset", {31'd0, bus.write_enable}, 32'd0);

    // random traffic, two rounds separated by reset
    for (int round = 0; round < 2; round++) begin
      for (int n = 0; n < 300; n++) begin
        logic        av, iv, bv;
        logic [4:0]  ai, ii, bi;
        logic [31:0] inq, cand;
        inq = '0;
        foreach (exp_q[j]) inq[exp_q[j][36:32]] = 1'b1;
        cand = m_pend & ~inq;
        av = ($urandom_range(0, 99) < 30);
        ai = 5'($urandom_range(0, 31));
        if (m_pend[ai] && $urandom_range(0, 9) != 0) ai = 5'd0;
        iv = ($urandom_range(0, 99) < 40);
        ii = 5'($urandom_range(0, 31));
        bv = 1'b0;
        bi = 5'($urandom_range(1, 31));
        if (cand != 0 && $urandom_range(0, 99) < 50) begin
          bv = 1'b1;
          for (int t = 0; t < 64; t++) begin
            if (cand[bi]) break;
            bi = 5'($urandom_range(1, 31));
          end
          if (!cand[bi]) bv = 1'b0;
        end else if ($urandom_range(0, 99) < 2) begin
          bv = 1'b1;
        end
        bus.query_index1 = 5'($urandom_range(0, 31));
        bus.query_index2 = 5'($urandom_range(0, 31));
        cycle(av, ai, $urandom, iv, ii, bv, bi, $urandom);
      end
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
